uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of payload bits per frame.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clock frequency in Hz, used to size the bit counter.
REQ-003 Localparam CLK_COUNTER_SIZE = $clog2((CLK_FREQ/300)*2); the bit counter SHALL be CLK_COUNTER_SIZE+1 bits wide.
REQ-004 clk  input  1: single clock; every register SHALL be clocked on its rising edge.
REQ-005 rst_l  input  1: reset; synchronous, active-low.
REQ-006 settings  input  tuner_output_bus: pulse_width, seniority_h, parity_on, parity_set, sbl.
REQ-007 signal  input  1: asynchronous serial line; idles high.
REQ-008 data  output  DATA_WIDTH: received word.
REQ-009 valid  output  1: data holds an unconsumed word.
REQ-010 ready  input  1: consumer accepts the word; a transfer occurs on any cycle where valid and ready are both high.
REQ-011 parity_err, frame_err, overrun  output  1 each: status flags qualified by valid.

Function
REQ-012 The signal input SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (sig_s).
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-014 Bit period SHALL be settings.pulse_width+1 clocks, which matches the transmitter.
REQ-015 IDLE: when sig_s goes from 1 to 0, the block SHALL latch settings for the whole frame, load the counter with pulse_width>>1, and go to START.
REQ-016 START: when the counter reaches 0, a low sig_s SHALL load the counter with pulse_width and go to DATA; a high sig_s SHALL be treated as a glitch and return to IDLE without any output change.
REQ-017 DATA: each time the counter reaches 0, the block SHALL sample sig_s into shift[idx] and reload pulse_width.
REQ-018 Bit index order: idx starts at DATA_WIDTH-1 and decrements when seniority_h=1; otherwise idx starts at 0 and increments.
REQ-019 After the last bit, the FSM SHALL go to PARITY if parity_on=1, otherwise to STOP.
REQ-020 PARITY: at mid-bit, the block SHALL compute parity_err = sig_s ^ (^shift) ^ parity_set, then go to STOP.
REQ-021 STOP: at mid-bit, the block SHALL set frame_err = ~sig_s and return to IDLE.
REQ-022 Only the first stop bit SHALL be checked, whatever sbl is set to.
REQ-023 Word publish happens in the cycle after the STOP sample: data, parity_err (0 when parity is off), frame_err and valid=1 SHALL be registered together.
REQ-024 A frame with frame_err=1 SHALL still be published.
REQ-025 valid SHALL stay high until a valid&ready transfer occurs, and SHALL deassert in the following cycle unless a new word is published in that same cycle.
REQ-026 Publish while valid=1 and ready=0: the new word SHALL overwrite the old one and overrun SHALL be set to 1.
REQ-027 Publish while ready=1: the old word counts as consumed, the new word is loaded, valid stays 1, and overrun=0.
REQ-028 A line held low after a frame (break) SHALL NOT start a new frame until sig_s has returned high and then falls again.

Reset
REQ-029 While rst_l=0 at a clock edge, the following SHALL be cleared: FSM=IDLE; counter, index and shift=0; data=0; valid=0; parity_err=0; frame_err=0; overrun=0; both synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame, and no word SHALL be published for it.

Structure
REQ-031 The rx state enum SHALL live in the shared uart package beside tuner_output_bus and the sbl enum (ONE, TWO, ONE_AND_HALF).
REQ-032 The synchronizer plus falling-edge detect SHALL be a sub-module named uart_rx_sync; the FSM, counters and output register SHALL stay in uart_rx.

Verification (DATA_WIDTH=8, pulse_width=15, i.e. a 16-clock bit)
REQ-033 Frame 0xA5, LSB first, parity off, ready=1 -> data=0xA5 and a 1-cycle valid pulse, with all flags 0.
REQ-034 Frame 0x3C, seniority_h=1, parity_on=1, parity_set=0, correct parity bit -> data=0x3C and parity_err=0; the same frame with the parity bit flipped -> parity_err=1.
REQ-035 Line low for 5 clocks, then high -> no valid and FSM back in IDLE; then frame 0x01 -> data=0x01.
REQ-036 Frame 0x55 with the stop bit driven low -> data=0x55 and frame_err=1; the line held low afterwards starts no second frame.
REQ-037 Two back-to-back frames 0x11 then 0x22 with ready=0 -> data=0x22 and overrun=1; then ready=1 for one cycle -> valid=0 on the next cycle.
REQ-038 rst_l=0 for 1 cycle at data bit 4 of frame 0xFF -> no valid; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: tuner settings bus, stop-bit length and receiver FSM states.
package uart_pkg;

   localparam int PULSE_W = 21;

   typedef enum logic [1:0] {
      ONE          = 2'd0,
      TWO          = 2'd1,
      ONE_AND_HALF = 2'd2
   } sbl_t;

   typedef struct packed {
      logic [PULSE_W-1:0] pulse_width;
      logic               seniority_h;
      logic               parity_on;
      logic               parity_set;
      sbl_t               sbl;
   } tuner_output_bus;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge strobe.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_l,
   input  logic signal,
   output logic sig_s,
   output logic fall
);

   logic meta;
   logic sig_d;

   // All flops reset high so an idle line never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         meta  <= 1'b1;
         sig_s <= 1'b1;
         sig_d <= 1'b1;
      end else begin
         meta  <= signal;
         sig_s <= meta;
         sig_d <= sig_s;
      end
   end

   assign fall = sig_d & ~sig_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling FSM with a single-entry output register and overrun flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_FREQ   = 100_000_000
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  tuner_output_bus       settings,
   input  logic                  signal,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int CLK_COUNTER_SIZE = $clog2((CLK_FREQ/300)*2);
   localparam int CNT_W = CLK_COUNTER_SIZE + 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   rx_state_t state, state_n;

   logic                  sig_s, fall;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] shift;
   logic [PULSE_W-1:0]    cfg_pw;
   logic                  cfg_sen, cfg_pon, cfg_pset;
   logic                  perr_q, ferr_q, pub_q;
   logic                  sbl_unused;

   logic cnt_zero, last_bit;
   logic latch_cfg, load_full, start_ok, sample_bit, chk_par, chk_stop;

   // Only the first stop bit is ever checked, so the stop-bit length is not needed here.
   assign sbl_unused = ^settings.sbl;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst_l  (rst_l),
      .signal (signal),
      .sig_s  (sig_s),
      .fall   (fall)
   );

   assign cnt_zero = (cnt == '0);
   assign last_bit = cfg_sen ? (idx == '0) : (idx == IDX_W'(DATA_WIDTH-1));

   always_ff @(posedge clk) begin
      if (!rst_l) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (fall) state_n = START;
         START:   if (cnt_zero) state_n = sig_s ? IDLE : DATA;
         DATA:    if (cnt_zero && last_bit) state_n = cfg_pon ? PARITY : STOP;
         PARITY:  if (cnt_zero) state_n = STOP;
         STOP:    if (cnt_zero) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      latch_cfg  = (state == IDLE) && fall;
      start_ok   = (state == START) && cnt_zero && !sig_s;
      sample_bit = (state == DATA) && cnt_zero;
      chk_par    = (state == PARITY) && cnt_zero;
      chk_stop   = (state == STOP) && cnt_zero;
      load_full  = start_ok || sample_bit || chk_par;
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         cnt      <= '0;
         idx      <= '0;
         shift    <= '0;
         cfg_pw   <= '0;
         cfg_sen  <= 1'b0;
         cfg_pon  <= 1'b0;
         cfg_pset <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         pub_q    <= 1'b0;
      end else begin
         pub_q <= chk_stop;
         if (latch_cfg) begin
            cfg_pw   <= settings.pulse_width;
            cfg_sen  <= settings.seniority_h;
            cfg_pon  <= settings.parity_on;
            cfg_pset <= settings.parity_set;
            perr_q   <= 1'b0;
            cnt      <= CNT_W'(settings.pulse_width >> 1);
         end else if (load_full) begin
            cnt <= CNT_W'(cfg_pw);
         end else if (state != IDLE && !cnt_zero) begin
            cnt <= cnt - 1'b1;
         end
         if (start_ok) idx <= cfg_sen ? IDX_W'(DATA_WIDTH-1) : '0;
         if (sample_bit) begin
            shift[idx] <= sig_s;
            if (!last_bit) idx <= cfg_sen ? idx - 1'b1 : idx + 1'b1;
         end
         if (chk_par)  perr_q <= sig_s ^ (^shift) ^ cfg_pset;
         if (chk_stop) ferr_q <= ~sig_s;
      end
   end

   // A publish while the old word is still pending overwrites it; ready in that cycle consumes it.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (pub_q) begin
         data       <= shift;
         valid      <= 1'b1;
         parity_err <= perr_q;
         frame_err  <= ferr_q;
         overrun    <= valid & ~ready;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected words popped on each valid&ready transfer.
module tb_uart_rx;
   import uart_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       perr;
      logic       ferr;
      logic       ovr;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   tuner_output_bus settings;
   logic            signal = 1'b1;
   logic [7:0]      data;
   logic            valid;
   logic            ready = 1'b1;
   logic            parity_err, frame_err, overrun;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   vcount = 0;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .settings   (settings),
      .signal     (signal),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every transfer must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_l && valid) vcount++;
      if (rst_l && valid && ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data", {24'd0, data}, {24'd0, e.d});
            chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
            chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            chk("overrun", {31'd0, overrun}, {31'd0, e.ovr});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      @(posedge clk);
      #1 signal = v;
      repeat (15) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit msb, input bit par,
                             input bit flip, input logic stopv);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(msb ? d[7-i] : d[i]);
      if (par) drive_bit((^d) ^ flip);
      drive_bit(stopv);
   endtask

   task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
      exp_t e;
      e.d = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
      sb.push_back(e);
   endtask

   task automatic set_cfg(input bit msb, input bit par);
      settings.pulse_width = PULSE_W'(15);
      settings.seniority_h = msb;
      settings.parity_on   = par;
      settings.parity_set  = 1'b0;
      settings.sbl         = ONE;
   endtask

   initial begin
      int v0;
      set_cfg(1'b0, 1'b0);

      // Reset state
      cycles(3);
      @(negedge clk);
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_perr", {31'd0, parity_err}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      chk("rst_state", {29'd0, dut.state}, {29'd0, IDLE});
      @(posedge clk); #1 rst_l = 1'b1;
      cycles(20);

      // 0xA5, LSB first, no parity: one-cycle valid pulse
      v0 = vcount;
      push(8'hA5, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      cycles(20);
      chk("a5_pulse_len", vcount - v0, 32'd1);
      chk("a5_valid_low", {31'd0, valid}, 32'd0);

      // 0x3C, MSB first, even parity: good then flipped parity bit
      set_cfg(1'b1, 1'b1);
      push(8'h3C, 1'b0, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      cycles(20);
      push(8'h3C, 1'b1, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
      cycles(20);

      // Short low glitch must not produce a word
      set_cfg(1'b0, 1'b0);
      v0 = vcount;
      @(posedge clk); #1 signal = 1'b0;
      cycles(5);
      signal = 1'b1;
      cycles(40);
      chk("glitch_no_valid", vcount - v0, 32'd0);
      chk("glitch_idle", {29'd0, dut.state}, {29'd0, IDLE});
      push(8'h01, 1'b0, 1'b0, 1'b0);
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
      cycles(20);

      // Framing error followed by a held-low break
      v0 = vcount;
      push(8'h55, 1'b0, 1'b1, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      cycles(300);
      chk("break_one_word", vcount - v0, 32'd1);
      chk("break_idle", {29'd0, dut.state}, {29'd0, IDLE});
      signal = 1'b1;
      cycles(40);

      // Back-to-back with ready low: overwrite and overrun
      ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      cycles(20);
      @(negedge clk);
      chk("ovr_valid", {31'd0, valid}, 32'd1);
      chk("ovr_data", {24'd0, data}, 32'h22);
      chk("ovr_flag", {31'd0, overrun}, 32'd1);
      push(8'h22, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1 ready = 1'b1;
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      chk("ovr_drained", {31'd0, valid}, 32'd0);
      ready = 1'b1;
      cycles(20);

      // Reset in the middle of data bit 4 of 0xFF abandons the frame
      v0 = vcount;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      @(posedge clk); #1 signal = 1'b1;
      cycles(7);
      rst_l = 1'b0;
      cycles(1);
      rst_l = 1'b1;
      cycles(8 + 4 * 16);
      chk("abort_no_valid", vcount - v0, 32'd0);
      chk("abort_idle", {29'd0, dut.state}, {29'd0, IDLE});
      push(8'h81, 1'b0, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      cycles(30);

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
